untap_stream_gen: RTL

Synthetic untapped-pixel source in the img_rx_clk domain. It generates frames of 160-bit words (16 pixels × 10 bit) with a valid strobe and a start-of-frame pulse. These outputs drive the cropping/CDC stage's untapFifo_In, fifoVld and new_frame_rx inputs, so that stage can be exercised without a sensor. Frame geometry, blanking and pixel pattern are programmable; it runs single-shot or continuously.

---
 rtl/untap_stream_gen.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/untap_stream_gen.sv
// untap_stream_gen: synthetic untapped-pixel frame source for the img_rx_clk
// domain. Emits 16-pixel x 10-bit words with a valid strobe, a start-of-frame
// pulse and programmable geometry, blanking and test pattern.
module untap_stream_gen #(
    parameter int GAP_W = 16
) (
    input  logic               img_rx_clk,
    input  logic               img_rx_rst_n,
    input  logic               enable,
    input  logic               start,
    input  logic               cont_mode,
    input  logic               hold,
    input  logic [11:0]        lineWidth,
    input  logic [15:0]        frameRows,
    input  logic [GAP_W-1:0]   lineGap,
    input  logic [GAP_W-1:0]   frameGap,
    input  logic [1:0]         pattern_sel,
    input  logic [9:0]         fixed_val,
    output logic               new_frame_rx,
    output logic               fifoVld,
    output logic [159:0]       untapFifo_In,
    output logic               frame_done,
    output logic [15:0]        frame_cnt,
    output logic               busy,
    output logic               cfg_err
);

    typedef enum logic [2:0] {
        IDLE,
        SOF,
        LINE,
        LGAP,
        FGAP
    } state_t;

    state_t             state, state_nxt;
    logic [8:0]         wcnt, wcnt_nxt;
    logic [15:0]        rcnt, rcnt_nxt;
    logic [GAP_W-1:0]   gcnt, gcnt_nxt;

    logic [11:0]        lw_q;
    logic [15:0]        rows_q;
    logic [GAP_W-1:0]   lgap_q;
    logic [GAP_W-1:0]   fgap_q;
    logic [1:0]         pat_q;
    logic [9:0]         fix_q;
    logic               latch_cfg;

    logic               vld_nxt, sof_nxt, done_nxt, err_nxt;
    logic [15:0]        fcnt_nxt;
    logic [159:0]       data_nxt, word_data;

    logic [8:0]         wpl;
    logic               last_word, last_row, cfg_ok, do_emit;
    logic [9:0]         col, pix;

    assign wpl       = {1'b0, lw_q[11:4]} + {8'd0, (lw_q[3:0] != 4'd0)};
    assign last_word = (wcnt == wpl - 9'd1);
    assign last_row  = (rcnt == rows_q - 16'd1);
    assign cfg_ok    = (lineWidth != 12'd0) && (frameRows != 16'd0);
    // The SOF cycle already carried new_frame_rx; the edge leaving SOF emits
    // word 0 exactly like LINE does, which keeps first fifoVld at T+2.
    assign do_emit   = enable && !hold && ((state == SOF) || (state == LINE));

    // Build the pixel word at the current (row, word) position from latched config.
    always_comb begin
        word_data = '0;
        col       = '0;
        pix       = '0;
        for (int unsigned k = 0; k < 16; k++) begin
            col = {wcnt[5:0], 4'(k)};
            case (pat_q)
                2'd0:    pix = col;
                2'd1:    pix = rcnt[9:0];
                2'd2:    pix = col ^ rcnt[9:0];
                default: pix = fix_q;
            endcase
            if (last_word && (lw_q[3:0] != 4'd0) && (4'(k) >= lw_q[3:0]))
                pix = '0;
            word_data[10*k +: 10] = pix;
        end
    end

    // Next-state, counter and next-output decode.
    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        rcnt_nxt  = rcnt;
        gcnt_nxt  = gcnt;
        vld_nxt   = 1'b0;
        sof_nxt   = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        fcnt_nxt  = frame_cnt;
        data_nxt  = untapFifo_In;
        latch_cfg = 1'b0;

        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            latch_cfg = 1'b1;
                            sof_nxt   = 1'b1;
                            wcnt_nxt  = '0;
                            rcnt_nxt  = '0;
                            gcnt_nxt  = '0;
                            state_nxt = SOF;
                        end else begin
                            err_nxt = 1'b1;
                        end
                    end
                end
                SOF:  state_nxt = LINE;
                LINE: state_nxt = LINE;
                LGAP: begin
                    if (!hold) begin
                        if (gcnt == lgap_q - GAP_W'(1)) begin
                            gcnt_nxt  = '0;
                            state_nxt = LINE;
                        end else begin
                            gcnt_nxt = gcnt + GAP_W'(1);
                        end
                    end
                end
                FGAP: begin
                    if (!hold) begin
                        if (gcnt == '0) begin
                            done_nxt = 1'b1;
                            fcnt_nxt = frame_cnt + 16'd1;
                        end
                        if (gcnt == fgap_q) begin
                            gcnt_nxt = '0;
                            if (cont_mode) begin
                                if (cfg_ok) begin
                                    latch_cfg = 1'b1;
                                    sof_nxt   = 1'b1;
                                    wcnt_nxt  = '0;
                                    rcnt_nxt  = '0;
                                    state_nxt = SOF;
                                end else begin
                                    err_nxt   = 1'b1;
                                    state_nxt = IDLE;
                                end
                            end else begin
                                state_nxt = IDLE;
                            end
                        end else begin
                            gcnt_nxt = gcnt + GAP_W'(1);
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase

            if (do_emit) begin
                vld_nxt  = 1'b1;
                data_nxt = word_data;
                if (last_word) begin
                    wcnt_nxt = '0;
                    gcnt_nxt = '0;
                    if (last_row) begin
                        state_nxt = FGAP;
                    end else begin
                        rcnt_nxt  = rcnt + 16'd1;
                        state_nxt = (lgap_q == '0) ? LINE : LGAP;
                    end
                end else begin
                    wcnt_nxt  = wcnt + 9'd1;
                    state_nxt = LINE;
                end
            end
        end
    end

    // State, counters, latched config and registered outputs.
    always_ff @(posedge img_rx_clk or negedge img_rx_rst_n) begin
        if (!img_rx_rst_n) begin
            state        <= IDLE;
            wcnt         <= '0;
            rcnt         <= '0;
            gcnt         <= '0;
            lw_q         <= '0;
            rows_q       <= '0;
            lgap_q       <= '0;
            fgap_q       <= '0;
            pat_q        <= '0;
            fix_q        <= '0;
            new_frame_rx <= 1'b0;
            fifoVld      <= 1'b0;
            untapFifo_In <= '0;
            frame_done   <= 1'b0;
            frame_cnt    <= '0;
            busy         <= 1'b0;
            cfg_err      <= 1'b0;
        end else begin
            state        <= state_nxt;
            wcnt         <= wcnt_nxt;
            rcnt         <= rcnt_nxt;
            gcnt         <= gcnt_nxt;
            if (latch_cfg) begin
                lw_q   <= lineWidth;
                rows_q <= frameRows;
                lgap_q <= lineGap;
                fgap_q <= frameGap;
                pat_q  <= pattern_sel;
                fix_q  <= fixed_val;
            end
            new_frame_rx <= sof_nxt;
            fifoVld      <= vld_nxt;
            untapFifo_In <= data_nxt;
            frame_done   <= done_nxt;
            frame_cnt    <= fcnt_nxt;
            busy         <= (state_nxt != IDLE);
            cfg_err      <= err_nxt;
        end
    end

endmodule
